// File: rtl/data_mem_ctrl_if.sv
// Bus bundle between the MEM stage, the load/store controller
// and the data SRAM.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_wen;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  req_valid, req_wr, req_size, req_signed,
        input  req_addr, req_wdata, resp_ready, sram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output sram_addr, sram_wen, sram_wdata
    );

    modport master (
        output req_valid, req_wr, req_size, req_signed,
        output req_addr, req_wdata, resp_ready, sram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  sram_addr, sram_wen, sram_wdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store controller for the word-only data SRAM.
// Sub-word stores are done as read-modify-write.
module data_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter bit ERR_OOR = 1'b1
) (
    input logic             clk,
    input logic             resetn,
    data_mem_ctrl_if.slave  bus
);
    localparam int AW = ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           wr_q;
    logic           signed_q;
    logic [1:0]     size_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    merged_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic           accept;
    logic           oor;
    logic           req_bad;
    logic [4:0]     bsh;
    logic [4:0]     hsh;
    logic [7:0]     rbyte;
    logic [15:0]    rhalf;
    logic [31:0]    ext;
    logic [31:0]    merged_d;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign oor    = ERR_OOR && ((bus.req_addr >> AW) != 32'd0);

    always_comb begin
        req_bad = oor;
        unique case (bus.req_size)
            2'b00:   req_bad = oor;
            2'b01:   req_bad = oor || bus.req_addr[0];
            2'b10:   req_bad = oor || (bus.req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign bsh   = {addr_q[1:0], 3'b000};
    assign hsh   = {addr_q[1], 4'b0000};
    assign rbyte = 8'(bus.sram_rdata >> bsh);
    assign rhalf = 16'(bus.sram_rdata >> hsh);

    always_comb begin
        ext      = bus.sram_rdata;
        merged_d = bus.sram_rdata;
        unique case (1'b1)
            size_q == 2'b00: begin
                ext      = {{24{signed_q & rbyte[7]}}, rbyte};
                merged_d = (bus.sram_rdata & ~(32'h0000_00ff << bsh))
                         | ({24'd0, wdata_q[7:0]} << bsh);
            end
            size_q == 2'b01: begin
                ext      = {{16{signed_q & rhalf[15]}}, rhalf};
                merged_d = (bus.sram_rdata & ~(32'h0000_ffff << hsh))
                         | ({16'd0, wdata_q[15:0]} << hsh);
            end
            default: begin
                ext      = bus.sram_rdata;
                merged_d = bus.sram_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Write strobes come from state_q only so reset kills them at once.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.sram_wen   = 4'h0;
        bus.sram_wdata = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                if (wr_q && size_q != 2'b10) begin
                    state_d = MERGE;
                end else begin
                    state_d = RESP;
                    if (wr_q) begin
                        bus.sram_wen   = 4'hf;
                        bus.sram_wdata = wdata_q;
                    end
                end
            end
            MERGE: begin
                state_d        = RESP;
                bus.sram_wen   = 4'hf;
                bus.sram_wdata = merged_q;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            merged_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_q     <= bus.req_wr;
                signed_q <= bus.req_signed;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr[AW-1:0];
                wdata_q  <= bus.req_wdata;
                err_q    <= req_bad;
                rdata_q  <= 32'd0;
            end
            if (state_q == ACCESS) begin
                merged_q <= merged_d;
                if (!wr_q) rdata_q <= ext;
            end
            if (state_q == RESP && bus.resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.sram_addr  = addr_q[AW-1:2];
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
